// File: rtl/program_counter_sequencer.sv
// Fetch-side program counter sequencer: steps the PC on accepted fetches, redirects on taken
// branches and then holds Flush for a fixed number of enabled cycles.
module program_counter_sequencer #(
   parameter int unsigned         AddrBits    = 32,
   parameter logic [AddrBits-1:0] ResetVector = '0,
   parameter logic [AddrBits-1:0] PcStep      = 1,
   parameter int unsigned         FlushCycles = 2
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Stall,
   input  logic                BranchTaken,
   input  logic [AddrBits-1:0] BranchDest,
   input  logic                Halt,
   input  logic                FetchAck,
   output logic [AddrBits-1:0] PC,
   output logic                FetchReq,
   output logic                Flush,
   output logic                Halted
);

   typedef enum logic [1:0] {StIdle, StFetch, StFlush, StHalt} state_e;

   // Counter holds the number of Flush cycles still to come after the current one.
   localparam logic [3:0] FlushReload = 4'(FlushCycles - 1);

   state_e     state_q;
   logic [3:0] flush_cnt_q;

   assign FetchReq = (state_q == StFetch) && !Stall;
   assign Halted   = (state_q == StHalt);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= StIdle;
         PC          <= ResetVector;
         flush_cnt_q <= '0;
         Flush       <= 1'b0;
      end else if (ClockEnable) begin
         unique case (state_q)
            StIdle: begin
               state_q <= StFetch;
               Flush   <= 1'b0;
            end
            StFetch: begin
               if (Halt) begin
                  state_q <= StHalt;
                  Flush   <= 1'b0;
               end else if (BranchTaken) begin
                  // Redirect wins over Stall; decode is being flushed anyway.
                  PC          <= BranchDest;
                  state_q     <= StFlush;
                  flush_cnt_q <= FlushReload;
                  Flush       <= 1'b1;
               end else if (FetchAck && FetchReq) begin
                  PC <= PC + PcStep;
               end
            end
            StFlush: begin
               if (Halt) begin
                  state_q <= StHalt;
                  Flush   <= 1'b0;
               end else if (BranchTaken) begin
                  PC          <= BranchDest;
                  flush_cnt_q <= FlushReload;
                  Flush       <= 1'b1;
               end else if (flush_cnt_q == 4'd0) begin
                  state_q <= StFetch;
                  Flush   <= 1'b0;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 4'd1;
               end
            end
            StHalt: begin
               Flush <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               Flush   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_counter_sequencer.sv
// Directed bench for program_counter_sequencer with AddrBits=8, ResetVector=0x10, FlushCycles=2.
module tb_program_counter_sequencer;

   logic       Clock;
   logic       Reset;
   logic       ClockEnable;
   logic       Stall;
   logic       BranchTaken;
   logic [7:0] BranchDest;
   logic       Halt;
   logic       FetchAck;
   logic [7:0] PC;
   logic       FetchReq;
   logic       Flush;
   logic       Halted;

   int checks = 0;
   int errors = 0;

   program_counter_sequencer #(
      .AddrBits   (8),
      .ResetVector(8'h10),
      .PcStep     (8'h01),
      .FlushCycles(2)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .ClockEnable(ClockEnable),
      .Stall      (Stall),
      .BranchTaken(BranchTaken),
      .BranchDest (BranchDest),
      .Halt       (Halt),
      .FetchAck   (FetchAck),
      .PC         (PC),
      .FetchReq   (FetchReq),
      .Flush      (Flush),
      .Halted     (Halted)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] pc, input logic req,
                             input logic fl, input logic hl);
      check({tag, ".pc"}, 32'(PC), 32'(pc));
      check({tag, ".req"}, 32'(FetchReq), 32'(req));
      check({tag, ".flush"}, 32'(Flush), 32'(fl));
      check({tag, ".halted"}, 32'(Halted), 32'(hl));
   endtask

   initial begin
      Reset = 1'b1; ClockEnable = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
      BranchDest = 8'h00; Halt = 1'b0; FetchAck = 1'b0;
      tick(); tick();
      expect_out("reset", 8'h10, 1'b0, 1'b0, 1'b0);

      // Run from reset with FetchAck held high
      Reset = 1'b0; ClockEnable = 1'b1; FetchAck = 1'b1;
      tick(); expect_out("run0", 8'h10, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("run1", 8'h11, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("run2", 8'h12, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("run3", 8'h13, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("run4", 8'h14, 1'b1, 1'b0, 1'b0);

      // Stall masks FetchReq combinationally; branch still taken under stall
      Stall = 1'b1; #1;
      check("stall_req", 32'(FetchReq), 32'd0);
      BranchTaken = 1'b1; BranchDest = 8'h40;
      tick(); BranchTaken = 1'b0; Stall = 1'b0; #1;
      expect_out("redir0", 8'h40, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("redir1", 8'h40, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("redir2", 8'h40, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("redir3", 8'h41, 1'b1, 1'b0, 1'b0);

      // Back-to-back branch restarts the flush window
      BranchTaken = 1'b1; BranchDest = 8'h40;
      tick(); expect_out("b2b0", 8'h40, 1'b0, 1'b1, 1'b0);
      BranchDest = 8'h80;
      tick(); BranchTaken = 1'b0; #1;
      expect_out("b2b1", 8'h80, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("b2b2", 8'h80, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("b2b3", 8'h80, 1'b1, 1'b0, 1'b0);

      // ClockEnable low freezes everything, including the flush counter
      BranchTaken = 1'b1; BranchDest = 8'h20;
      tick(); expect_out("ce0", 8'h20, 1'b0, 1'b1, 1'b0);
      ClockEnable = 1'b0; BranchDest = 8'h55; Halt = 1'b1;
      tick(); expect_out("ce_off0", 8'h20, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("ce_off1", 8'h20, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("ce_off2", 8'h20, 1'b0, 1'b1, 1'b0);
      BranchTaken = 1'b0; Halt = 1'b0; ClockEnable = 1'b1;
      tick(); expect_out("ce1", 8'h20, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("ce2", 8'h20, 1'b1, 1'b0, 1'b0);

      // Wrap-around from 0xFF
      BranchTaken = 1'b1; BranchDest = 8'hFF;
      tick(); BranchTaken = 1'b0; #1;
      tick(); tick(); expect_out("wrap0", 8'hFF, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("wrap1", 8'h00, 1'b1, 1'b0, 1'b0);

      // Halt beats BranchTaken; only Reset leaves HALT
      Halt = 1'b1; BranchTaken = 1'b1; BranchDest = 8'h77;
      tick(); Halt = 1'b0; #1;
      expect_out("halt0", 8'h00, 1'b0, 1'b0, 1'b1);
      tick(); BranchTaken = 1'b0; #1;
      expect_out("halt1", 8'h00, 1'b0, 1'b0, 1'b1);
      tick(); expect_out("halt2", 8'h00, 1'b0, 1'b0, 1'b1);
      Reset = 1'b1;
      tick(); expect_out("halt_rst", 8'h10, 1'b0, 1'b0, 1'b0);

      // Reset mid-FLUSH applies even with ClockEnable low
      Reset = 1'b0;
      tick(); expect_out("rf0", 8'h10, 1'b1, 1'b0, 1'b0);
      BranchTaken = 1'b1; BranchDest = 8'h33;
      tick(); BranchTaken = 1'b0; #1;
      expect_out("rf1", 8'h33, 1'b0, 1'b1, 1'b0);
      ClockEnable = 1'b0; Reset = 1'b1;
      tick(); expect_out("rf2", 8'h10, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0; ClockEnable = 1'b1;
      tick(); expect_out("rf3", 8'h10, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_counter_sequencer.md
# program_counter_sequencer

Fetch-side program counter sequencer for the recognition CPU. It holds the PC, steps it on each accepted instruction fetch, and redirects it to the branch destination address on a taken branch. A redirect is followed by a fixed pipeline flush window. It sits directly downstream of the branch destination address register: that register's Q output drives BranchDest, and this block's PC output feeds instruction memory.

## Interface
Parameters:
- AddrBits, 32, width of PC and BranchDest.
- ResetVector, 0, PC value after reset.
- PcStep, 1, PC increment per accepted fetch (word addressing).
- FlushCycles, 2, number of cycles Flush is held after a redirect; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- ClockEnable  in  1  when low, all state holds and all inputs are ignored.
- Stall  in  1  back-pressure from decode; holds PC and suppresses FetchReq.
- BranchTaken  in  1  single-cycle pulse from execute: redirect to BranchDest.
- BranchDest  in  AddrBits  branch destination address, valid when BranchTaken=1.
- Halt  in  1  halt instruction retired.
- FetchAck  in  1  instruction memory accepted the current FetchReq.
- PC  out  AddrBits  current fetch address (registered).
- FetchReq  out  1  fetch request, decoded as (state==FETCH) && !Stall.
- Flush  out  1  kill in-flight fetch/decode stages (registered from state).
- Halted  out  1  high in HALT (decoded from state).

## Operation
- States are IDLE, FETCH, FLUSH and HALT. A flush counter of 4 bits tracks the FLUSH window.
- Reset sets state to IDLE and PC to ResetVector. All outputs are then 0 except PC.
- IDLE moves to FETCH on the first cycle with ClockEnable=1.
- Priority within a cycle with ClockEnable=1 is Halt > BranchTaken > (FetchAck && FetchReq) > hold.
- In FETCH:
  - BranchTaken=1: PC <= BranchDest, state <= FLUSH, counter <= FlushCycles-1. This applies even when Stall=1.
  - Otherwise, FetchAck && FetchReq: PC <= PC + PcStep.
  - FetchAck while FetchReq=0 is ignored.
- In FLUSH:
  - Flush=1 and FetchReq=0.
  - The counter decrements each enabled cycle.
  - At counter==0 the state moves to FETCH.
  - BranchTaken in FLUSH reloads PC with the new BranchDest and restarts the counter at FlushCycles-1.
- HALT is entered from any state except IDLE when Halt=1.
  - In HALT: PC frozen, FetchReq=0, Flush=0, Halted=1.
  - Only Reset leaves HALT. BranchTaken and FetchAck are ignored.
- Arithmetic: PC + PcStep is computed modulo 2^AddrBits. No carry out and no error flag.
- If ClockEnable=0 and Reset=1, reset still applies, because reset is not gated by ClockEnable.

## Timing
- A PC update is visible on the cycle after the accepting edge. Latency from FetchAck to the new PC is 1 cycle.
- Redirect: BranchTaken sampled at edge N gives PC=BranchDest and Flush=1 from cycle N+1.
  - Flush stays high for exactly FlushCycles enabled cycles.
  - FetchReq returns high in the following cycle if Stall=0.
- Stall acts combinationally on FetchReq in the same cycle. It never blocks Halt or BranchTaken.
- Reset asserted mid-FLUSH or mid-HALT takes effect at the next edge. The counter is cleared.
- Cycles with ClockEnable=0 do not count toward FlushCycles.

## Test plan
All scenarios use AddrBits=8, ResetVector=0x10, PcStep=1, FlushCycles=2.
- Reset then run: release Reset, ClockEnable=1, FetchAck=1 constant -> cycle 1 in FETCH with PC=0x10, then PC=0x11, 0x12, 0x13 on successive cycles, FetchReq=1 throughout.
- Wrap-around: with PC=0xFF, FetchAck=1 -> PC=0x00 next cycle.
- Redirect with Stall: at PC=0x14, Stall=1, BranchTaken=1, BranchDest=0x40 -> next cycle PC=0x40 and Flush=1 for 2 cycles with FetchReq=0. With Stall=0, FetchReq=1 on the 3rd cycle.
- Back-to-back branch: BranchDest=0x40, then BranchTaken with BranchDest=0x80 during the first FLUSH cycle -> PC=0x80, Flush held 2 more cycles (3 in total).
- Halt priority: Halt=1 and BranchTaken=1 in the same cycle -> Halted=1, PC unchanged, FetchReq=0. Later FetchAck or BranchTaken pulses leave PC unchanged. Reset gives PC=0x10, Halted=0.
- ClockEnable gating: ClockEnable=0 for 3 cycles during FLUSH with FetchAck=1 -> PC and counter frozen. Flush is still released after 2 enabled cycles.
